// File: rtl/add_serial_sched.sv
// add_serial_sched: round-robin scheduler that shares one bit-serial adder
// (start/done handshake) among NREQ requesters.
// Each accepted operand pair goes to the adder, and the sum comes back on a
// valid/ready response channel tagged with the requester id.
//
// Ports:
//   clk, rst           clock (rising edge), asynchronous active-high reset
//   req                per-requester level request, held until its gnt bit is seen
//   req_a, req_b       operands; requester i is at [i*W +: W]
//   gnt                one-hot grant, valid only in IDLE (same cycle as req)
//   add_en             1-cycle start pulse to the adder
//   add_a, add_b       adder operands, stable from add_en until add_done
//   add_done, add_sum  adder completion pulse and result
//   rsp_valid/ready    response handshake
//   rsp_id, rsp_sum    requester id and sum (modulo 2^W)
//   rsp_err            adder timeout flag
//
// Optional feature: define ADD_SCHED_TIMEOUT_EN to abort WAIT after TMO_CYC cycles
// without add_done. The response then has rsp_sum=0 and rsp_err=1.
// When the macro is undefined, WAIT holds indefinitely and rsp_err is tied to 0.
module add_serial_sched #(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned W       = 8,
    parameter int unsigned IDW     = 2,
    parameter int unsigned TMO_CYC = 31
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    output logic [NREQ-1:0]   gnt,
    output logic              add_en,
    output logic [W-1:0]      add_a,
    output logic [W-1:0]      add_b,
    input  logic              add_done,
    input  logic [W-1:0]      add_sum,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic [W-1:0]      rsp_sum,
    output logic              rsp_err
);

    // Reject parameter sets the id field or arbiter cannot represent.
    if (NREQ < 2 || NREQ > 8 || (1 << IDW) < NREQ || TMO_CYC < 1) begin : g_cfg_err
        $error("add_serial_sched: unsupported parameter set");
    end

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t         state;
    logic [IDW-1:0] ptr;
    logic [IDW-1:0] win;
    logic           found;

`ifdef ADD_SCHED_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TMO_CYC + 1);
    logic [CW-1:0] cnt;
`endif

    // Round-robin search: the requester after the last winner has top priority.
    always_comb begin
        int unsigned    idx;
        logic [IDW-1:0] cand;
        win   = '0;
        found = 1'b0;
        idx   = 0;
        cand  = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            idx = 32'(ptr) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            cand = IDW'(idx);
            if (!found && req[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    // Grant is a same-cycle decode so an idle scheduler accepts with zero latency.
    always_comb begin
        gnt = '0;
        if (state == S_IDLE && found && !rst) begin
            gnt = NREQ'(1) << win;
        end
    end

    // Scheduler FSM with registered adder and response outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            ptr       <= IDW'(NREQ - 1);
            add_en    <= 1'b0;
            add_a     <= '0;
            add_b     <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_sum   <= '0;
`ifdef ADD_SCHED_TIMEOUT_EN
            rsp_err   <= 1'b0;
            cnt       <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (found) begin
                        add_a  <= req_a[win*W +: W];
                        add_b  <= req_b[win*W +: W];
                        rsp_id <= win;
                        ptr    <= win;
                        add_en <= 1'b1;
                        state  <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    add_en <= 1'b0;
                    state  <= S_WAIT;
`ifdef ADD_SCHED_TIMEOUT_EN
                    cnt    <= '0;
`endif
                end
                S_WAIT: begin
                    // add_done wins over a timeout expiring in the same cycle.
                    if (add_done) begin
                        rsp_sum   <= add_sum;
                        rsp_valid <= 1'b1;
                        state     <= S_RESP;
`ifdef ADD_SCHED_TIMEOUT_EN
                        rsp_err   <= 1'b0;
                    end else if (cnt == CW'(TMO_CYC - 1)) begin
                        rsp_sum   <= '0;
                        rsp_err   <= 1'b1;
                        rsp_valid <= 1'b1;
                        state     <= S_RESP;
                    end else begin
                        cnt <= cnt + CW'(1);
`endif
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifndef ADD_SCHED_TIMEOUT_EN
    assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_add_serial_sched.sv
// Testbench for add_serial_sched.
// Requester and adder behaviour is generated here, and a scoreboard checks every grant and response.
module tb_add_serial_sched;
    localparam int unsigned NREQ    = 4;
    localparam int unsigned W       = 8;
    localparam int unsigned IDW     = 2;
    localparam int unsigned TMO_CYC = 31;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NREQ-1:0]   req = '0;
    logic [NREQ*W-1:0] req_a = '0;
    logic [NREQ*W-1:0] req_b = '0;
    logic [NREQ-1:0]   gnt;
    logic              add_en;
    logic [W-1:0]      add_a;
    logic [W-1:0]      add_b;
    logic              add_done = 1'b0;
    logic [W-1:0]      add_sum = '0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b0;
    logic [IDW-1:0]    rsp_id;
    logic [W-1:0]      rsp_sum;
    logic              rsp_err;

    always #5 clk = ~clk;

    add_serial_sched #(.NREQ(NREQ), .W(W), .IDW(IDW), .TMO_CYC(TMO_CYC)) dut (
        .clk(clk), .rst(rst), .req(req), .req_a(req_a), .req_b(req_b), .gnt(gnt),
        .add_en(add_en), .add_a(add_a), .add_b(add_b), .add_done(add_done),
        .add_sum(add_sum), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_sum(rsp_sum), .rsp_err(rsp_err)
    );

    typedef struct {
        int         id;
        logic [W-1:0] sum;
        logic       err;
    } exp_t;

    exp_t exp_q[$];
    int   gnt_log[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   mptr = NREQ - 1;
    bit   busy = 1'b0;
    int   en_cnt = 0;
    bit   granted[NREQ];
    int   adder_cnt = 0;
    logic [W-1:0] ad_a = '0;
    logic [W-1:0] ad_b = '0;
    bit   random_mode = 1'b0;
    bit   stray_en = 1'b0;
    bit   hold_all = 1'b0;
    bit   adder_mute = 1'b0;
    bit   expect_tmo = 1'b0;
    bit   ready_force = 1'b1;
    int   fixed_lat = 8;
    int   en_cyc = 0;
    int   rsp_cyc = -1;
    int   valid_seen = 0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
        end
    endfunction

    always @(posedge clk) cyc++;

    // Monitor and scoreboard: compares grants, adder handshakes and responses on the falling edge.
    always @(negedge clk) begin
        logic [NREQ-1:0] exp_g;
        int w;
        exp_t e;
        if (!rst) begin
            exp_g = '0;
            w = -1;
            if (!busy && req != '0) begin
                for (int k = 1; k <= NREQ; k++) begin
                    int idx;
                    idx = (mptr + k) % NREQ;
                    if (w < 0 && req[idx]) w = idx;
                end
                exp_g[w] = 1'b1;
            end
            check("gnt", 32'(gnt), 32'(exp_g));
            if (w >= 0) begin
                e.id  = w;
                e.sum = expect_tmo ? '0 : W'(req_a[w*W +: W] + req_b[w*W +: W]);
                e.err = expect_tmo;
                exp_q.push_back(e);
                gnt_log.push_back(w);
                mptr = w;
                busy = 1'b1;
                en_cnt = 0;
                granted[w] = 1'b1;
            end
            if (add_en) begin
                en_cnt++;
                check("add_en_in_op", 32'(busy), 32'(1));
                check("add_en_adder_idle", 32'(adder_cnt), 32'(0));
                ad_a = add_a;
                ad_b = add_b;
                adder_cnt = (fixed_lat > 0) ? fixed_lat : int'($urandom_range(1, 10));
                en_cyc = cyc;
            end else if (adder_cnt > 0 && busy) begin
                check("add_op_stable", 32'({add_a, add_b}), 32'({ad_a, ad_b}));
            end
            if (rsp_valid) begin
                valid_seen++;
                if (rsp_cyc < 0) rsp_cyc = cyc;
                if (exp_q.size() == 0) begin
                    check("rsp_unexpected", 32'(rsp_valid), 32'(0));
                end else begin
                    check("rsp_id", 32'(rsp_id), 32'(exp_q[0].id));
                    check("rsp_sum", 32'(rsp_sum), 32'(exp_q[0].sum));
                    check("rsp_err", 32'(rsp_err), 32'(exp_q[0].err));
                    if (rsp_ready) begin
                        check("add_en_count", 32'(en_cnt), 32'(1));
                        void'(exp_q.pop_front());
                        busy = 1'b0;
                    end
                end
            end
        end
    end

    // Adder model: answers with the sum after the chosen latency. It can also pulse done when no operation is active.
    always @(posedge clk) begin
        #1;
        add_done = 1'b0;
        if (adder_cnt > 0) begin
            adder_cnt--;
            if (adder_cnt == 0 && !adder_mute) begin
                add_done = 1'b1;
                add_sum  = W'(ad_a + ad_b);
            end
        end else if (stray_en && $urandom_range(0, 7) == 0) begin
            add_done = 1'b1;
            add_sum  = W'($urandom);
        end
    end

    // Requester model: drops or re-arms its request after a grant, and raises new random requests.
    always @(posedge clk) begin
        #1;
        if (!rst) begin
            for (int i = 0; i < NREQ; i++) begin
                if (granted[i]) begin
                    granted[i] = 1'b0;
                    if (!hold_all) begin
                        if (random_mode && $urandom_range(0, 1) == 1) begin
                            req_a[i*W +: W] = W'($urandom);
                            req_b[i*W +: W] = W'($urandom);
                        end else begin
                            req[i] = 1'b0;
                        end
                    end
                end else if (random_mode && !req[i] && $urandom_range(0, 3) == 0) begin
                    req_a[i*W +: W] = W'($urandom);
                    req_b[i*W +: W] = W'($urandom);
                    req[i] = 1'b1;
                end
            end
            rsp_ready = random_mode ? ($urandom_range(0, 3) != 0) : ready_force;
        end
    end

    task automatic issue(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        @(posedge clk);
        #2;
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
        req[i] = 1'b1;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((busy || exp_q.size() != 0 || req != '0) && t < 400) begin
            @(posedge clk);
            t++;
        end
        if (t >= 400) begin
            checks++;
            errors++;
            $display("FAIL drain: scheduler still busy after %0d cycles", t);
        end
    endtask

    task automatic wait_valid();
        int t;
        t = 0;
        while (!rsp_valid && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) begin
            checks++;
            errors++;
            $display("FAIL wait_valid: no rsp_valid within %0d cycles", t);
        end
    endtask

    initial begin
        int t;
        int exp_order[5];
        exp_order = '{0, 1, 2, 3, 0};

        // Reset: outputs low, and requests during reset get no grant.
        req = 4'b1111;
        repeat (2) @(negedge clk);
        check("reset_ctl", 32'({gnt, add_en, rsp_valid, rsp_err, rsp_id}), 32'(0));
        check("reset_data", 32'({add_a, add_b, rsp_sum}), 32'(0));
        req = '0;
        @(posedge clk);
        #2 rst = 1'b0;

        // Single requester 2 with the adder replying after 8 cycles.
        stray_en = 1'b1;
        fixed_lat = 8;
        ready_force = 1'b1;
        issue(2, 8'h35, 8'h4A);
        drain();

        // Sum wraps; rsp_ready is held low so the response stalls while requester 3 waits.
        ready_force = 1'b0;
        issue(0, 8'hFF, 8'h02);
        issue(3, 8'h11, 8'h22);
        wait_valid();
        repeat (5) @(negedge clk);
        check("stall_valid", 32'(rsp_valid), 32'(1));
        check("stall_sum", 32'(rsp_sum), 32'(8'h01));
        check("stall_no_gnt", 32'(gnt), 32'(0));
        ready_force = 1'b1;
        drain();

        // All four requesters held high: grants rotate.
        gnt_log.delete();
        hold_all = 1'b1;
        @(posedge clk);
        #2;
        for (int i = 0; i < NREQ; i++) begin
            req_a[i*W +: W] = W'(8'h10 * i + 1);
            req_b[i*W +: W] = W'(8'h20 + i);
        end
        req = 4'b1111;
        t = 0;
        while (gnt_log.size() < 5 && t < 300) begin
            @(posedge clk);
            t++;
        end
        @(posedge clk);
        #2;
        hold_all = 1'b0;
        req = '0;
        drain();
        for (int i = 0; i < 5; i++) begin
            check("rr_order", 32'((i < gnt_log.size()) ? gnt_log[i] : -1), 32'(exp_order[i]));
        end

        // Randomized traffic with random latency and backpressure.
        random_mode = 1'b1;
        fixed_lat = 0;
        repeat (3000) @(posedge clk);
        random_mode = 1'b0;
        ready_force = 1'b1;
        drain();

        // Reset during WAIT: the operation is dropped and a late add_done is ignored.
        stray_en = 1'b0;
        fixed_lat = 8;
        issue(2, 8'h12, 8'h34);
        t = 0;
        while (adder_cnt == 0 && t < 50) begin
            @(negedge clk);
            t++;
        end
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        check("rst_mid_ctl", 32'({gnt, add_en, rsp_valid, rsp_err, rsp_id}), 32'(0));
        check("rst_mid_data", 32'({add_a, add_b, rsp_sum}), 32'(0));
        exp_q.delete();
        busy = 1'b0;
        mptr = NREQ - 1;
        for (int i = 0; i < NREQ; i++) granted[i] = 1'b0;
        req = '0;
        @(posedge clk);
        #2 rst = 1'b0;
        valid_seen = 0;
        repeat (12) @(negedge clk);
        check("late_done_no_rsp", 32'(valid_seen), 32'(0));
        gnt_log.delete();
        @(posedge clk);
        #2 req = 4'b1111;
        drain();
        check("after_rst_first", 32'((gnt_log.size() > 0) ? gnt_log[0] : -1), 32'(0));

`ifdef ADD_SCHED_TIMEOUT_EN
        // Adder never responds: the scheduler responds with an error after TMO_CYC WAIT cycles.
        adder_mute = 1'b1;
        expect_tmo = 1'b1;
        rsp_cyc = -1;
        issue(1, 8'h05, 8'h06);
        t = 0;
        while (rsp_cyc < 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("tmo_latency", 32'(rsp_cyc - en_cyc), 32'(TMO_CYC + 1));
        drain();
        adder_mute = 1'b0;
        expect_tmo = 1'b0;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish (errors=%0d checks=%0d)", errors, checks);
        $fatal(1);
    end

endmodule
